muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Multi-cycle sequencer for the RV32M integer multiply/divide unit in the Execute stage. It accepts one MUL/DIV/REM operation from decode, stalls the front of the pipeline while an iterative shift-add or shift-subtract datapath runs, applies sign correction, and presents a one-cycle result for the Execute output register. Fast paths cover divide-by-zero and signed overflow.

## Interface
- XLEN, 32, operand/result width
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  1  decode presents an M-extension op; sampled only in IDLE
- req_op  in  e_muldiv_op (3)  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- req_rs1  in  XLEN  operand A, already forwarded
- req_rs2  in  XLEN  operand B, already forwarded
- req_rd  in  MSB_REG_FILE  destination register
- flush  in  1  synchronous kill; pipeline redirect
- stall  out  1  hold IF/ID and the Execute input registers
- result_valid  out  1  result, result_rd valid this cycle
- result  out  XLEN  final value
- result_rd  out  MSB_REG_FILE  destination of result

## Operation
- States: IDLE, BUSY, FIX, DONE.
- IDLE, req_valid=1, special case → DONE; otherwise → BUSY, iter count=0. Capture op and rd. Load |rs1| and |rs2| by signedness: MULH/DIV/REM both signed; MULHSU rs1 signed only; MUL/MULHU/DIVU/REMU unsigned. Record the result sign.
- Special cases, registered directly into result:
  - DIV/DIVU with rs2=0 → 0xFFFFFFFF.
  - REM/REMU with rs2=0 → rs1.
  - DIV with rs1=0x80000000 and rs2=0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- BUSY: one iteration per cycle, 32 iterations on a 5-bit counter.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, giving a 32-bit quotient and remainder.
  - Counter wrap 31→0 → FIX.
- FIX: conditional two's-complement negate.
  - Multiply negates the 64-bit product when signs differ.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Select the word: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits; DIV/DIVU quotient; REM/REMU remainder. Register it into result → DONE.
- DONE: result_valid=1 for exactly one cycle → IDLE. req_valid is ignored in DONE, because it is the same instruction being released.
- stall = (IDLE & req_valid) | BUSY | FIX. Combinational from state and req_valid.
- flush (any state) → IDLE at the next edge; result_valid=0 next cycle; no result is produced. flush has priority over acceptance in IDLE.
- Arithmetic is modulo 2^XLEN. A negate of 0x80000000 yields 0x80000000.

## Timing
- Reset: state=IDLE, counter=0, result_valid=0, result=0, result_rd=0, stall=0 (unless IDLE & req_valid).
- Normal op, request in cycle C0:
  - BUSY in C1..C32, FIX in C33, DONE in C34.
  - result_valid in C34; latency 34.
  - stall high C0..C33 (34 cycles), low in C34.
- Special case: result_valid in C1; stall high in C0 only.
- Back-to-back ops: the next req is accepted no earlier than the cycle after DONE.
- Reset mid-operation: immediate return to IDLE with reset values; the partial result is discarded.
- result and result_rd hold their value after DONE until the next completion. Consumers qualify them with result_valid.

## Structure
- control_pkg gets e_muldiv_op, a 3-bit encoding in funct3 order: MUL=0 … REMU=7.
- The state enum and the iteration constant (32) are local.
- One sub-module, muldiv_iter_dp, holds the accumulator, the divisor/remainder shift registers and the per-iteration add/subtract. It is controlled by load, step and op-class inputs.
- The sequencer owns the FSM, counter, special-case detection, FIX negation and output registers.

## Test plan
- DIVU 100/7 → result 14 in C34; REMU 100/7 → 2; stall high exactly 34 cycles.
- REM rs1=0xFFFFFFF9 (−7), rs2=2 → 0xFFFFFFFF; DIV same operands → 0xFFFFFFFD (−3).
- DIV rs2=0 → 0xFFFFFFFF in C1. DIV 0x80000000/0xFFFFFFFF → 0x80000000 in C1; stall only in C0.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0; MULHU same → 0xFFFFFFFE; MUL same → 1; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- flush in C10 of a DIV → IDLE at C11, no result_valid. A new MUL 3×5 in C12 → 15 in C46.
- rstn low in C20 of a MUL → all outputs at reset values immediately. After release, held req_valid restarts the op with full 34-cycle latency.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
package muldiv_sequencer_pkg;

  localparam int XLEN         = 32;
  localparam int MSB_REG_FILE = 5;

  // M-extension operations, encoded in funct3 order
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } e_muldiv_op;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic rs1_is_signed(input e_muldiv_op op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic rs2_is_signed(input e_muldiv_op op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Two's-complement negate when neg is set; 0x80000000 maps onto itself
  function automatic logic [XLEN-1:0] negate_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// Iterative datapath: one shift-add (multiply) or restoring shift-subtract
// (divide) step per cycle on unsigned magnitudes.
// Multiply: acc[31:0] starts as the multiplier and acc[63:32] collects partial
// sums; after 32 steps acc holds the 64-bit product.
// Divide: acc[31:0] starts as the dividend and fills with quotient bits from
// the right; acc[63:32] is the running remainder.
module muldiv_iter_dp
  import muldiv_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   opa,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   quotient,
  output logic [XLEN-1:0]   remainder
);

  logic [2*XLEN-1:0] acc_reg;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   b_reg;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN+1:0]   rem_diff;

  // Compute the next accumulator value for one iteration of either operation
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, b_reg} : '0);
    rem_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    rem_diff  = {1'b0, rem_shift} - {2'b00, b_reg};
    acc_next  = acc_reg;
    if (is_div) begin
      if (!rem_diff[XLEN+1]) begin
        acc_next = {rem_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {rem_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next = {mul_sum, acc_reg[XLEN-1:1]};
    end
  end

  // Operand load and per-cycle iteration
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_reg <= '0;
      b_reg   <= '0;
    end else if (load) begin
      acc_reg <= {{XLEN{1'b0}}, opa};
      b_reg   <= opb;
    end else if (step) begin
      acc_reg <= acc_next;
    end
  end

  assign product   = acc_reg;
  assign quotient  = acc_reg[XLEN-1:0];
  assign remainder = acc_reg[2*XLEN-1:XLEN];

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: accepts one op, stalls the front end while the
// iterative datapath runs, sign-corrects, and releases a one-cycle result.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  input  e_muldiv_op              req_op,
  input  logic [XLEN-1:0]         req_rs1,
  input  logic [XLEN-1:0]         req_rs2,
  input  logic [MSB_REG_FILE-1:0] req_rd,
  input  logic                    flush,
  output logic                    stall,
  output logic                    result_valid,
  output logic [XLEN-1:0]         result,
  output logic [MSB_REG_FILE-1:0] result_rd
);

  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

  state_t                    state_reg, state_next;
  logic [CNT_W-1:0]          count_reg;
  e_muldiv_op                op_reg;
  logic [MSB_REG_FILE-1:0]   rd_reg;
  logic                      neg_q_reg;
  logic                      neg_r_reg;
  logic [XLEN-1:0]           result_reg;
  logic [MSB_REG_FILE-1:0]   result_rd_reg;

  logic                      accept;
  logic                      dp_load;
  logic                      dp_step;
  logic                      fix_done;

  logic                      neg_a, neg_b;
  logic [XLEN-1:0]           mag_a, mag_b;
  logic                      rs2_zero, overflow, special;
  logic [XLEN-1:0]           special_result;

  logic [2*XLEN-1:0]         dp_product;
  logic [XLEN-1:0]           dp_quotient, dp_remainder;
  logic [2*XLEN-1:0]         prod_fixed;
  logic [XLEN-1:0]           fix_result;

  // Operand magnitudes, sign bookkeeping and fast-path detection at acceptance
  always_comb begin
    neg_a    = rs1_is_signed(req_op) & req_rs1[XLEN-1];
    neg_b    = rs2_is_signed(req_op) & req_rs2[XLEN-1];
    mag_a    = negate_if(neg_a, req_rs1);
    mag_b    = negate_if(neg_b, req_rs2);
    rs2_zero = (req_rs2 == '0);
    overflow = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
               (req_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_rs2 == '1);
    special  = req_op[2] & (rs2_zero | overflow);
    // req_op[1] separates REM/REMU from DIV/DIVU within the divide class
    if (rs2_zero) begin
      special_result = req_op[1] ? req_rs1 : '1;
    end else begin
      special_result = req_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  muldiv_iter_dp u_dp (
    .clk       (clk),
    .rstn      (rstn),
    .load      (dp_load),
    .step      (dp_step),
    .is_div    (op_reg[2]),
    .opa       (mag_a),
    .opb       (mag_b),
    .product   (dp_product),
    .quotient  (dp_quotient),
    .remainder (dp_remainder)
  );

  // Sign correction and word selection for the FIX state
  always_comb begin
    prod_fixed = neg_q_reg ? (~dp_product + 1'b1) : dp_product;
    fix_result = '0;
    case (op_reg)
      OP_MUL:                       fix_result = prod_fixed[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fixed[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_result = negate_if(neg_q_reg, dp_quotient);
      OP_REM, OP_REMU:              fix_result = negate_if(neg_r_reg, dp_remainder);
      default:                      fix_result = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and control strobes; flush overrides everything, including acceptance
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    dp_load    = 1'b0;
    dp_step    = 1'b0;
    fix_done   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (special) begin
            state_next = S_DONE;
          end else begin
            dp_load    = 1'b1;
            state_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        dp_step = 1'b1;
        if (count_reg == LAST_ITER) begin
          state_next = S_FIX;
        end
      end
      S_FIX: begin
        fix_done   = 1'b1;
        state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) begin
      state_next = S_IDLE;
      accept     = 1'b0;
      dp_load    = 1'b0;
      dp_step    = 1'b0;
      fix_done   = 1'b0;
    end
  end

  // Iteration counter: cleared on load, wraps 31 -> 0 as BUSY ends
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (dp_load || flush) begin
      count_reg <= '0;
    end else if (dp_step) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Capture the accepted op, destination and result signs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_reg    <= OP_MUL;
      rd_reg    <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (accept) begin
      op_reg    <= req_op;
      rd_reg    <= req_rd;
      neg_q_reg <= neg_a ^ neg_b;
      neg_r_reg <= neg_a;
    end
  end

  // Result registers load on a fast-path accept or at the end of FIX, else hold
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      result_reg    <= '0;
      result_rd_reg <= '0;
    end else if (accept && special) begin
      result_reg    <= special_result;
      result_rd_reg <= req_rd;
    end else if (fix_done) begin
      result_reg    <= fix_result;
      result_rd_reg <= rd_reg;
    end
  end

  assign stall        = ((state_reg == S_IDLE) & req_valid) | (state_reg == S_BUSY) | (state_reg == S_FIX);
  assign result_valid = (state_reg == S_DONE);
  assign result       = result_reg;
  assign result_rd    = result_rd_reg;

endmodule
